// File: rtl/regfile_pkg.sv
// Shared widths and the write-request payload for the register-file writer side.
package regfile_pkg;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_req_t;
endpackage

// File: rtl/regfile_write_arbiter_wb_fifo.sv
// In-order buffer for multi-cycle results waiting for a free write-port slot.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  wb_req_t                push_data,
  input  logic                   pop,
  output wb_req_t                pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_req_t          mem_q [DEPTH];
  wb_req_t          mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok_c, pop_ok_c;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign pop_data  = mem_q[rd_ptr_q];
  assign push_ok_c = push && !full;
  assign pop_ok_c  = pop && !empty;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok_c) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_ok_c) - CNT_W'(pop_ok_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Sole driver of the register-file write port: merges pipeline writeback with buffered
// multi-cycle results and tracks per-register busy state for RAW hazard detection.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_a,
  input  logic [DATA_W-1:0]     wb_wd,
  input  logic                  mc_valid,
  output logic                  mc_ready,
  input  logic [REG_ADDR_W-1:0] mc_a,
  input  logic [DATA_W-1:0]     mc_wd,
  input  logic                  mc_issue,
  input  logic [REG_ADDR_W-1:0] mc_issue_a,
  input  logic [REG_ADDR_W-1:0] q_a1,
  input  logic [REG_ADDR_W-1:0] q_a2,
  output logic                  haz1,
  output logic                  haz2,
  output logic                  drain_req,
  output logic                  err,
  output logic                  we3,
  output logic [REG_ADDR_W-1:0] a3,
  output logic [DATA_W-1:0]     wd3
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                  we3_q, we3_d;
  logic [REG_ADDR_W-1:0] a3_q, a3_d;
  logic [DATA_W-1:0]     wd3_q, wd3_d;
  logic                  src_mc_q, src_mc_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic                  err_q, err_d;

  logic                  wb_valid_c, fifo_push_c, fifo_pop_c;
  logic                  fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  wb_req_t               fifo_head, fifo_in;

  assign fifo_in     = '{addr: mc_a, data: mc_wd};
  assign mc_ready    = (fifo_count < CNT_W'(DEPTH));
  assign drain_req   = fifo_full;
  assign wb_valid_c  = wb_we && (wb_a != '0);
  assign fifo_push_c = mc_valid && mc_ready;
  assign fifo_pop_c  = !wb_valid_c && !fifo_empty;

  assign haz1 = (q_a1 != '0) && busy_q[q_a1];
  assign haz2 = (q_a2 != '0) && busy_q[q_a2];
  assign err  = err_q;
  assign we3  = we3_q;
  assign a3   = a3_q;
  assign wd3  = wd3_q;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push_c),
    .push_data (fifo_in),
    .pop       (fifo_pop_c),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Write-port select: writeback wins; register-0 FIFO entries drain without a write.
  always_comb begin
    we3_d    = 1'b0;
    a3_d     = a3_q;
    wd3_d    = wd3_q;
    src_mc_d = 1'b0;
    if (wb_valid_c) begin
      we3_d = 1'b1;
      a3_d  = wb_a;
      wd3_d = wb_wd;
    end else if (fifo_pop_c) begin
      we3_d    = (fifo_head.addr != '0);
      a3_d     = fifo_head.addr;
      wd3_d    = fifo_head.data;
      src_mc_d = 1'b1;
    end
  end

  // Clear lands on the same edge the regfile commits; a same-edge issue re-marks busy.
  always_comb begin
    busy_d = busy_q;
    err_d  = err_q;
    if (we3_q && src_mc_q) busy_d[a3_q] = 1'b0;
    if (mc_issue && (mc_issue_a != '0)) begin
      busy_d[mc_issue_a] = 1'b1;
      if (busy_q[mc_issue_a]) err_d = 1'b1;
    end
    if (wb_we && (wb_a != '0) && busy_q[wb_a]) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we3_q    <= 1'b0;
      a3_q     <= '0;
      wd3_q    <= '0;
      src_mc_q <= 1'b0;
      busy_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      we3_q    <= we3_d;
      a3_q     <= a3_d;
      wd3_q    <= wd3_d;
      src_mc_q <= src_mc_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end
endmodule
